// File: rtl/siw_memory_bram_reader_if.sv
// Bus bundle between the strided BRAM reader and its surroundings (sequencer, memory port, stream sink).
// Optional stall counter port appears when SIW_MEM_RD_STALL_CNT_EN is defined.
interface siw_memory_bram_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                siw_memory_bram_reader_init;
    logic                siw_memory_bram_reader_start;
    logic [ADDR_W-1:0]   siw_memory_bram_reader_base_addr;
    logic [ADDR_W-1:0]   siw_memory_bram_reader_stride;
    logic [ADDR_W:0]     siw_memory_bram_reader_count;
    logic                siw_memory_bram_reader_busy;
    logic                siw_memory_bram_reader_done;
    logic                siw_memory_bram_reader_mem_enable;
    logic                siw_memory_bram_reader_mem_write_en;
    logic [ADDR_W-1:0]   siw_memory_bram_reader_mem_address;
    logic [DATA_W-1:0]   siw_memory_bram_reader_mem_data;
    logic                siw_memory_bram_reader_out_valid;
    logic                siw_memory_bram_reader_out_ready;
    logic [DATA_W-1:0]   siw_memory_bram_reader_out_data;
    logic                siw_memory_bram_reader_out_last;
`ifdef SIW_MEM_RD_STALL_CNT_EN
    logic [15:0]         siw_memory_bram_reader_stall_cnt;
`endif

    modport master (
        input  siw_memory_bram_reader_init,
        input  siw_memory_bram_reader_start,
        input  siw_memory_bram_reader_base_addr,
        input  siw_memory_bram_reader_stride,
        input  siw_memory_bram_reader_count,
        output siw_memory_bram_reader_busy,
        output siw_memory_bram_reader_done,
        output siw_memory_bram_reader_mem_enable,
        output siw_memory_bram_reader_mem_write_en,
        output siw_memory_bram_reader_mem_address,
        input  siw_memory_bram_reader_mem_data,
        output siw_memory_bram_reader_out_valid,
        input  siw_memory_bram_reader_out_ready,
        output siw_memory_bram_reader_out_data,
`ifdef SIW_MEM_RD_STALL_CNT_EN
        output siw_memory_bram_reader_stall_cnt,
`endif
        output siw_memory_bram_reader_out_last
    );

    modport slave (
        output siw_memory_bram_reader_init,
        output siw_memory_bram_reader_start,
        output siw_memory_bram_reader_base_addr,
        output siw_memory_bram_reader_stride,
        output siw_memory_bram_reader_count,
        input  siw_memory_bram_reader_busy,
        input  siw_memory_bram_reader_done,
        input  siw_memory_bram_reader_mem_enable,
        input  siw_memory_bram_reader_mem_write_en,
        input  siw_memory_bram_reader_mem_address,
        output siw_memory_bram_reader_mem_data,
        input  siw_memory_bram_reader_out_valid,
        output siw_memory_bram_reader_out_ready,
        input  siw_memory_bram_reader_out_data,
`ifdef SIW_MEM_RD_STALL_CNT_EN
        input  siw_memory_bram_reader_stall_cnt,
`endif
        input  siw_memory_bram_reader_out_last
    );
endinterface

// File: rtl/siw_memory_bram_reader.sv
// Strided BRAM read initiator: issues credit-limited reads, absorbs the read latency, streams words out.
// Define SIW_MEM_RD_STALL_CNT_EN to add the downstream stall cycle counter.
module siw_memory_bram_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     siw_memory_bram_reader_clk,
    input  logic                     siw_memory_bram_reader_reset,
    siw_memory_bram_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = PTR_W + 2;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    logic clk;
    logic rst;
    assign clk = siw_memory_bram_reader_clk;
    assign rst = siw_memory_bram_reader_reset;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CRD_W-1:0]    inflight_q, inflight_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
`ifdef SIW_MEM_RD_STALL_CNT_EN
    logic [15:0]         stall_q, stall_d;
`endif

    logic [PTR_W:0]      occ;
    logic                fifo_empty;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_word;
    logic [RD_LAT-1:0]   pipe_shift;

    always_comb begin
        occ        = wr_ptr_q - rd_ptr_q;
        fifo_empty = (occ == '0);
        // Words in flight already own a buffer slot, so the FIFO can never overflow.
        credit_ok  = (CRD_W'(occ) + inflight_q) < CRD_W'(FIFO_DEPTH);
        issue      = (state_q == ISSUE) && !bus.siw_memory_bram_reader_init && credit_ok;
        push       = pipe_q[RD_LAT-1];
        pop        = !fifo_empty && bus.siw_memory_bram_reader_out_ready;
        last_word  = (idx_q == count_q - CNT_W'(1));
    end

    genvar gi;
    assign pipe_shift[0] = issue;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            assign pipe_shift[gi] = pipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        count_d    = count_q;
        remain_d   = remain_q;
        idx_d      = idx_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pipe_d     = pipe_shift;
        done_d     = 1'b0;
`ifdef SIW_MEM_RD_STALL_CNT_EN
        stall_d    = stall_q;
`endif
        if (bus.siw_memory_bram_reader_init) begin
            // Abort: anything still coming back from memory is dropped.
            state_d    = IDLE;
            idx_d      = '0;
            inflight_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pipe_d     = '0;
`ifdef SIW_MEM_RD_STALL_CNT_EN
            stall_d    = '0;
`endif
        end else begin
            inflight_d = inflight_q + CRD_W'(issue) - CRD_W'(push);
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                idx_d    = idx_q + CNT_W'(1);
            end
`ifdef SIW_MEM_RD_STALL_CNT_EN
            if ((state_q != IDLE) && !fifo_empty && !bus.siw_memory_bram_reader_out_ready
                && (stall_q != 16'hFFFF))
                stall_d = stall_q + 16'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.siw_memory_bram_reader_start) begin
                        addr_d   = bus.siw_memory_bram_reader_base_addr;
                        stride_d = bus.siw_memory_bram_reader_stride;
                        count_d  = bus.siw_memory_bram_reader_count;
                        remain_d = bus.siw_memory_bram_reader_count;
                        idx_d    = '0;
`ifdef SIW_MEM_RD_STALL_CNT_EN
                        stall_d  = '0;
`endif
                        if (bus.siw_memory_bram_reader_count == '0) done_d = 1'b1;
                        else                                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_d   = addr_q + stride_q;
                        remain_d = remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            idx_q      <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_q     <= '0;
            done_q     <= 1'b0;
`ifdef SIW_MEM_RD_STALL_CNT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pipe_q     <= pipe_d;
            done_q     <= done_d;
`ifdef SIW_MEM_RD_STALL_CNT_EN
            stall_q    <= stall_d;
`endif
        end
    end

    // Buffer storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.siw_memory_bram_reader_mem_data;
    end

    assign bus.siw_memory_bram_reader_busy         = (state_q != IDLE);
    assign bus.siw_memory_bram_reader_done         = done_q;
    assign bus.siw_memory_bram_reader_mem_enable   = issue;
    assign bus.siw_memory_bram_reader_mem_write_en = 1'b0;
    assign bus.siw_memory_bram_reader_mem_address  = addr_q;
    assign bus.siw_memory_bram_reader_out_valid    = !fifo_empty;
    assign bus.siw_memory_bram_reader_out_data     = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.siw_memory_bram_reader_out_last     = !fifo_empty && last_word;
`ifdef SIW_MEM_RD_STALL_CNT_EN
    assign bus.siw_memory_bram_reader_stall_cnt    = stall_q;
`endif
endmodule

// File: tb/tb_siw_memory_bram_reader.sv
// Directed bench for siw_memory_bram_reader with a two-stage BRAM model and a stream monitor.
// Stall counter checks are compiled in when SIW_MEM_RD_STALL_CNT_EN is defined.
module tb_siw_memory_bram_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    siw_memory_bram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    siw_memory_bram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .siw_memory_bram_reader_clk   (clk),
        .siw_memory_bram_reader_reset (rst),
        .bus                          (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    int          issued_addr [$];
    int          issue_cyc   [$];
    logic [31:0] rx_data     [$];
    bit          rx_last     [$];
    int          rx_cyc      [$];
    int          done_cycles = 0;

    function automatic logic [31:0] memf(input logic [9:0] a);
        return 32'hA5C3_0000 ^ {6'd0, a, 6'd0, a};
    endfunction

    // Memory port: address register into BRAM, then output register (RD_LAT = 2).
    logic [31:0] mem_r1, mem_r2;
    always @(posedge clk) begin
        mem_r1 <= memf(bus.siw_memory_bram_reader_mem_address);
        mem_r2 <= mem_r1;
    end
    assign bus.siw_memory_bram_reader_mem_data = mem_r2;

    always @(posedge clk) cyc <= cyc + 1;

    // Records what the next rising edge will commit.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.siw_memory_bram_reader_mem_enable) begin
                issued_addr.push_back(int'(bus.siw_memory_bram_reader_mem_address));
                issue_cyc.push_back(cyc);
            end
            if (bus.siw_memory_bram_reader_out_valid && bus.siw_memory_bram_reader_out_ready) begin
                rx_data.push_back(bus.siw_memory_bram_reader_out_data);
                rx_last.push_back(bus.siw_memory_bram_reader_out_last);
                rx_cyc.push_back(cyc);
            end
            if (bus.siw_memory_bram_reader_done) done_cycles++;
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        issued_addr.delete(); issue_cyc.delete();
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        done_cycles = 0;
    endtask

    // Returns just after the edge that samples start; parameters are scrambled afterwards.
    task automatic start_xfer(input logic [9:0] base, input logic [9:0] stride, input logic [10:0] cnt);
        clear_mon();
        bus.siw_memory_bram_reader_base_addr = base;
        bus.siw_memory_bram_reader_stride    = stride;
        bus.siw_memory_bram_reader_count     = cnt;
        bus.siw_memory_bram_reader_start     = 1'b1;
        tick();
        bus.siw_memory_bram_reader_start     = 1'b0;
        bus.siw_memory_bram_reader_base_addr = base ^ 10'h155;
        bus.siw_memory_bram_reader_stride    = stride + 10'd7;
        bus.siw_memory_bram_reader_count     = 11'd1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.siw_memory_bram_reader_done) begin
                seen = 1;
                break;
            end
        end
        check_vec({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick();
        tick();
    endtask

    task automatic verify(input logic [9:0] base, input logic [9:0] stride, input int cnt, input string tag);
        logic [9:0] a;
        $display("xfer %s: base=%0d stride=%0d count=%0d issued=%0d received=%0d",
                 tag, base, stride, cnt, issued_addr.size(), rx_data.size());
        check_vec({tag, "_n_issue"}, 64'(issued_addr.size()), 64'(cnt));
        check_vec({tag, "_n_rx"}, 64'(rx_data.size()), 64'(cnt));
        for (int k = 0; k < cnt; k++) begin
            a = base + 10'(k) * stride;
            if (k < issued_addr.size())
                check_vec($sformatf("%s_addr%0d", tag, k), 64'(issued_addr[k]), 64'(a));
            if (k < rx_data.size()) begin
                check_vec($sformatf("%s_data%0d", tag, k), 64'(rx_data[k]), 64'(memf(a)));
                check_vec($sformatf("%s_last%0d", tag, k), 64'(rx_last[k]), 64'(k == cnt - 1));
            end
        end
        check_vec({tag, "_done_cycles"}, 64'(done_cycles), 64'd1);
        check_vec({tag, "_busy_end"}, 64'(bus.siw_memory_bram_reader_busy), 64'd0);
        check_vec({tag, "_valid_end"}, 64'(bus.siw_memory_bram_reader_out_valid), 64'd0);
    endtask

    initial begin
        bus.siw_memory_bram_reader_init      = 1'b0;
        bus.siw_memory_bram_reader_start     = 1'b0;
        bus.siw_memory_bram_reader_base_addr = '0;
        bus.siw_memory_bram_reader_stride    = '0;
        bus.siw_memory_bram_reader_count     = '0;
        bus.siw_memory_bram_reader_out_ready = 1'b1;
        tick(); tick();

        check_vec("rst_busy",   64'(bus.siw_memory_bram_reader_busy), 64'd0);
        check_vec("rst_done",   64'(bus.siw_memory_bram_reader_done), 64'd0);
        check_vec("rst_en",     64'(bus.siw_memory_bram_reader_mem_enable), 64'd0);
        check_vec("rst_we",     64'(bus.siw_memory_bram_reader_mem_write_en), 64'd0);
        check_vec("rst_addr",   64'(bus.siw_memory_bram_reader_mem_address), 64'd0);
        check_vec("rst_valid",  64'(bus.siw_memory_bram_reader_out_valid), 64'd0);
        check_vec("rst_data",   64'(bus.siw_memory_bram_reader_out_data), 64'd0);
        check_vec("rst_last",   64'(bus.siw_memory_bram_reader_out_last), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // Linear read of 8 words with latency and throughput checks.
        start_xfer(10'd0, 10'd1, 11'd8);
        check_vec("lin_busy", 64'(bus.siw_memory_bram_reader_busy), 64'd1);
        check_vec("lin_en0", 64'(bus.siw_memory_bram_reader_mem_enable), 64'd1);
        tick();
        tick();
        check_vec("lin_valid_e2", 64'(bus.siw_memory_bram_reader_out_valid), 64'd0);
        tick();
        check_vec("lin_valid_e3", 64'(bus.siw_memory_bram_reader_out_valid), 64'd1);
        wait_done(60, "lin");
        verify(10'd0, 10'd1, 8, "lin");
        if (issue_cyc.size() == 8) check_vec("lin_issue_span", 64'(issue_cyc[7] - issue_cyc[0]), 64'd7);
        if (rx_cyc.size() == 8)    check_vec("lin_rx_span", 64'(rx_cyc[7] - rx_cyc[0]), 64'd7);

        // Address wrap: 1020, 1023, 2, 5.
        start_xfer(10'd1020, 10'd3, 11'd4);
        wait_done(60, "wrap");
        verify(10'd1020, 10'd3, 4, "wrap");
        if (issued_addr.size() == 4) begin
            check_vec("wrap_a1", 64'(issued_addr[1]), 64'd1023);
            check_vec("wrap_a2", 64'(issued_addr[2]), 64'd2);
            check_vec("wrap_a3", 64'(issued_addr[3]), 64'd5);
        end

        // Backpressure: ready low across sampling edges E0..E19 of the transfer.
        bus.siw_memory_bram_reader_out_ready = 1'b0;
        start_xfer(10'd40, 10'd1, 11'd16);
        repeat (19) tick();
        check_vec("bp_issue_cap", 64'(issued_addr.size()), 64'(FIFO_DEPTH));
        check_vec("bp_valid_held", 64'(bus.siw_memory_bram_reader_out_valid), 64'd1);
        check_vec("bp_data_held", 64'(bus.siw_memory_bram_reader_out_data), 64'(memf(10'd40)));
        check_vec("bp_rx_none", 64'(rx_data.size()), 64'd0);
        bus.siw_memory_bram_reader_out_ready = 1'b1;
        wait_done(100, "bp");
        verify(10'd40, 10'd1, 16, "bp");
`ifdef SIW_MEM_RD_STALL_CNT_EN
        check_vec("bp_stall_cnt", 64'(bus.siw_memory_bram_reader_stall_cnt), 64'(20 - (RD_LAT + 2)));
`endif

        // Zero-length transfer.
        start_xfer(10'd9, 10'd1, 11'd0);
        check_vec("zero_done", 64'(bus.siw_memory_bram_reader_done), 64'd1);
        check_vec("zero_busy", 64'(bus.siw_memory_bram_reader_busy), 64'd0);
        tick();
        check_vec("zero_done_drop", 64'(bus.siw_memory_bram_reader_done), 64'd0);
        repeat (4) tick();
        check_vec("zero_no_issue", 64'(issued_addr.size()), 64'd0);
        check_vec("zero_done_cycles", 64'(done_cycles), 64'd1);

        // Abort after three accepted words, then a fresh 2-word transfer.
        start_xfer(10'd100, 10'd1, 11'd10);
        for (int i = 0; i < 40 && rx_data.size() < 3; i++) tick();
        check_vec("init_three_words", 64'(rx_data.size() >= 3), 64'd1);
        bus.siw_memory_bram_reader_init = 1'b1;
        tick();
        bus.siw_memory_bram_reader_init = 1'b0;
        check_vec("init_busy", 64'(bus.siw_memory_bram_reader_busy), 64'd0);
        check_vec("init_valid", 64'(bus.siw_memory_bram_reader_out_valid), 64'd0);
        repeat (5) tick();
        check_vec("init_no_done", 64'(done_cycles), 64'd0);
        check_vec("init_valid_late", 64'(bus.siw_memory_bram_reader_out_valid), 64'd0);
        start_xfer(10'd200, 10'd5, 11'd2);
        wait_done(60, "post");
        verify(10'd200, 10'd5, 2, "post");

        // Second start while busy must be ignored.
        start_xfer(10'd50, 10'd2, 11'd6);
        tick();
        bus.siw_memory_bram_reader_base_addr = 10'd0;
        bus.siw_memory_bram_reader_stride    = 10'd1;
        bus.siw_memory_bram_reader_count     = 11'd3;
        bus.siw_memory_bram_reader_start     = 1'b1;
        tick();
        bus.siw_memory_bram_reader_start     = 1'b0;
        wait_done(60, "restart");
        verify(10'd50, 10'd2, 6, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
